wvb_writer: RTL and testbench

WVB_WRITER -- requirements
Module: wvb_writer

---
 rtl/wvb_pkg.sv | 47 ++++
 rtl/wvb_writer_if.sv | 28 ++
 rtl/wvb_pretrig_delay.sv | 26 ++
 rtl/wvb_writer.sv | 160 ++++++++++++++++
 tb/tb_wvb_writer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wvb_pkg.sv
// Shared definitions for the waveform buffer writer: data-word and header
// field positions, FSM state encoding and the word/header packing helpers.
package wvb_pkg;

  localparam int WORD_W      = 22;
  localparam int HDR_W       = 80;
  localparam int W_EOE_BIT   = 21;
  localparam int W_DISCR_BIT = 20;
  localparam int W_ADC_LSB   = 0;
  localparam int ADC_W       = 12;
  localparam int H_LTC_LSB   = 32;
  localparam int H_START_LSB = 20;
  localparam int H_STOP_LSB  = 8;
  localparam int H_SRC_LSB   = 4;
  localparam int LTC_W       = 48;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_HDR    = 2'd2
  } wvb_state_e;

  // Pack one delayed sample {discr, adc} into a data word.
  function automatic logic [WORD_W-1:0] make_word(input logic eoe, input logic [12:0] sample);
    logic [WORD_W-1:0] w;
    w = '0;
    w[W_EOE_BIT] = eoe;
    w[W_DISCR_BIT] = sample[12];
    w[W_ADC_LSB +: ADC_W] = sample[11:0];
    return w;
  endfunction

  // Pack a waveform header; address fields are already 12 bits wide.
  function automatic logic [HDR_W-1:0] make_hdr(input logic [LTC_W-1:0] ltc,
                                                input logic [11:0] start_adr,
                                                input logic [11:0] stop_adr,
                                                input logic [3:0] src);
    logic [HDR_W-1:0] h;
    h = '0;
    h[H_LTC_LSB +: LTC_W] = ltc;
    h[H_START_LSB +: 12] = start_adr;
    h[H_STOP_LSB +: 12] = stop_adr;
    h[H_SRC_LSB +: 4] = src;
    return h;
  endfunction

endpackage

// File: rtl/wvb_writer_if.sv
// Reader-side bus of the waveform buffer: data/header pops, release pulse
// and buffer status. The reader is the master, the writer the slave.
interface wvb_writer_if;
  import wvb_pkg::*;

  logic              wvb_rdreq;
  logic              hdr_rdreq;
  logic              wvb_rddone;
  logic [WORD_W-1:0] wvb_data_out;
  logic [HDR_W-1:0]  hdr_data_out;
  logic              hdr_empty;
  logic              hdr_full;
  logic [15:0]       n_wvf_in_buf;
  logic [15:0]       wused;
  logic              overflow;

  modport master (
    output wvb_rdreq, hdr_rdreq, wvb_rddone,
    input  wvb_data_out, hdr_data_out, hdr_empty, hdr_full,
           n_wvf_in_buf, wused, overflow
  );

  modport slave (
    input  wvb_rdreq, hdr_rdreq, wvb_rddone,
    output wvb_data_out, hdr_data_out, hdr_empty, hdr_full,
           n_wvf_in_buf, wused, overflow
  );
endinterface

// File: rtl/wvb_pretrig_delay.sv
// Pre-trigger delay line: tap_o is din_i delayed by dly_i cycles (0..31).
// A delay of 0 taps the live input, so only 31 stored stages are ever read.
module wvb_pretrig_delay (
  input  logic        clk,
  input  logic [12:0] din_i,
  input  logic [4:0]  dly_i,
  output logic [12:0] tap_o
);
  logic [12:0] sr_q [0:31];

  // Shift register; sr_q[i] holds the sample from i+1 cycles ago (not reset).
  always_ff @(posedge clk) begin
    sr_q[0] <= din_i;
    for (int i = 1; i < 32; i++) begin
      sr_q[i] <= sr_q[i-1];
    end
  end

  // Select the live sample or the stored stage matching the requested delay.
  always_comb begin
    tap_o = din_i;
    if (dly_i != 5'd0) begin
      tap_o = sr_q[dly_i - 5'd1];
    end
  end
endmodule

// File: rtl/wvb_writer.sv
// Waveform buffer writer: records triggered waveforms (with pre-trigger
// samples) into a circular data RAM and queues one header per waveform.
module wvb_writer
  import wvb_pkg::*;
#(
  parameter int P_ADR_WIDTH = 12,
  parameter int P_HDR_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] adc_in,
  input  logic        discr_in,
  input  logic        trig,
  input  logic [3:0]  trig_src,
  input  logic        armed,
  input  logic [4:0]  pre_conf,
  input  logic [7:0]  post_conf,
  input  logic [47:0] ltc_in,
  wvb_writer_if.slave rd_if
);
  localparam int HDR_AW = $clog2(P_HDR_DEPTH);
  localparam logic [16:0] MEM_WORDS = 17'(1 << P_ADR_WIDTH);
  localparam logic [P_ADR_WIDTH-1:0] ADR_ONE = P_ADR_WIDTH'(1);
  localparam logic [HDR_AW:0] HDR_FULL_CNT = (HDR_AW+1)'(P_HDR_DEPTH);

  wvb_state_e             state_q;
  logic [P_ADR_WIDTH-1:0] wr_ptr_q, rd_ptr_q, start_q;
  logic [8:0]             remain_q;
  logic [4:0]             pre_q;
  logic [3:0]             src_q;
  logic [47:0]            ltc_start_q;
  logic [15:0]            wused_q, n_wvf_q;
  logic                   ovf_q;
  logic [WORD_W-1:0]      data_q;
  logic [HDR_AW:0]        hdr_wr_q, hdr_rd_q;
  logic [WORD_W-1:0]      mem_q [0:(1<<P_ADR_WIDTH)-1];
  logic [HDR_W-1:0]       hdr_mem_q [0:P_HDR_DEPTH-1];

  logic [8:0]        n_words;
  logic              space_ok, hdr_full_w, hdr_empty_w;
  logic              trig_ok, accept, reject, wr_en, eoe, push, pop, hpop, wvf_dec;
  logic [4:0]        tap_dly;
  logic [12:0]       tap;
  logic [HDR_AW:0]   hdr_cnt;
  logic [HDR_W-1:0]  hdr_word;

  // The configured pre-trigger delay is used on the acceptance cycle, the
  // latched one for the rest of the waveform.
  assign tap_dly = (state_q == ST_IDLE) ? pre_conf : pre_q;

  wvb_pretrig_delay u_dly (
    .clk   (clk),
    .din_i ({discr_in, adc_in}),
    .dly_i (tap_dly),
    .tap_o (tap)
  );

  assign n_words     = 9'(pre_conf) + 9'(post_conf) + 9'd1;
  assign space_ok    = (MEM_WORDS - {1'b0, wused_q}) >= 17'(n_words);
  assign hdr_cnt     = hdr_wr_q - hdr_rd_q;
  assign hdr_full_w  = (hdr_cnt == HDR_FULL_CNT);
  assign hdr_empty_w = (hdr_wr_q == hdr_rd_q);
  assign trig_ok     = (state_q == ST_IDLE) && trig && armed;
  assign accept      = trig_ok && space_ok && !hdr_full_w;
  assign reject      = trig_ok && !accept;
  assign wr_en       = accept || (state_q == ST_RECORD);
  assign eoe         = (state_q == ST_RECORD) ? (remain_q == 9'd1) : (n_words == 9'd1);
  assign push        = (state_q == ST_HDR);
  assign pop         = rd_if.wvb_rdreq && (wused_q != 16'd0);
  assign hpop        = rd_if.hdr_rdreq && !hdr_empty_w;
  assign wvf_dec     = rd_if.wvb_rddone && (n_wvf_q != 16'd0);
  // In HDR the write pointer sits one past the waveform's last word.
  assign hdr_word    = make_hdr(ltc_start_q, 12'(start_q), 12'(wr_ptr_q - ADR_ONE), src_q);

  // Capture state: accept/reject triggers, count waveform words, emit header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      pre_q       <= '0;
      src_q       <= '0;
      ltc_start_q <= '0;
      start_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            pre_q       <= pre_conf;
            src_q       <= trig_src;
            ltc_start_q <= ltc_in - 48'(pre_conf);
            start_q     <= wr_ptr_q;
            remain_q    <= n_words - 9'd1;
            state_q     <= (n_words == 9'd1) ? ST_HDR : ST_RECORD;
          end
          if (reject) begin
            ovf_q <= 1'b1;
          end
        end
        ST_RECORD: begin
          remain_q <= remain_q - 9'd1;
          if (remain_q == 9'd1) begin
            state_q <= ST_HDR;
          end
        end
        ST_HDR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pointers, occupancy counters and the registered data-RAM read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wused_q  <= '0;
      n_wvf_q  <= '0;
      hdr_wr_q <= '0;
      hdr_rd_q <= '0;
      data_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + ADR_ONE;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ADR_ONE;
        data_q   <= mem_q[rd_ptr_q];
      end
      case ({wr_en, pop})
        2'b10:   wused_q <= wused_q + 16'd1;
        2'b01:   wused_q <= wused_q - 16'd1;
        default: wused_q <= wused_q;
      endcase
      case ({push, wvf_dec})
        2'b10:   n_wvf_q <= n_wvf_q + 16'd1;
        2'b01:   n_wvf_q <= n_wvf_q - 16'd1;
        default: n_wvf_q <= n_wvf_q;
      endcase
      if (push) hdr_wr_q <= hdr_wr_q + 1'b1;
      if (hpop) hdr_rd_q <= hdr_rd_q + 1'b1;
    end
  end

  // Data RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= make_word(eoe, tap);
  end

  // Header FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push) hdr_mem_q[hdr_wr_q[HDR_AW-1:0]] <= hdr_word;
  end

  assign rd_if.wvb_data_out = data_q;
  assign rd_if.hdr_data_out = hdr_mem_q[hdr_rd_q[HDR_AW-1:0]];
  assign rd_if.hdr_empty    = hdr_empty_w;
  assign rd_if.hdr_full     = hdr_full_w;
  assign rd_if.n_wvf_in_buf = n_wvf_q;
  assign rd_if.wused        = wused_q;
  assign rd_if.overflow     = ovf_q;
endmodule

// File: tb/tb_wvb_writer.sv
// Testbench for wvb_writer: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the buffer.
module tb_wvb_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] adc_in = '0;
  logic        discr_in = 1'b0;
  logic        trig = 1'b0;
  logic [3:0]  trig_src = '0;
  logic        armed = 1'b0;
  logic [4:0]  pre_conf = '0;
  logic [7:0]  post_conf = '0;
  logic [47:0] ltc_in = '0;

  wvb_writer_if rd_if ();

  wvb_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_in    (adc_in),
    .discr_in  (discr_in),
    .trig      (trig),
    .trig_src  (trig_src),
    .armed     (armed),
    .pre_conf  (pre_conf),
    .post_conf (post_conf),
    .ltc_in    (ltc_in),
    .rd_if     (rd_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: sample history by cycle, expected data/header queues.
  logic [12:0] hist [int];
  logic [21:0] mq [$];
  logic [79:0] mhq [$];
  int          mwused = 0, mnwvf = 0, mwr_total = 0;
  bit          movf = 1'b0;
  int          cyc = 0, busy_until = 0;
  int          acc_c = 0, acc_n = 0, acc_pre = 0, acc_start = 0;
  logic [3:0]  acc_src = '0;
  logic [47:0] acc_ltc = '0;
  logic [47:0] ltc_v = 48'd60;
  bit          in_reset = 1'b0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mhq.delete();
    mwused = 0; mnwvf = 0; mwr_total = 0; movf = 1'b0; busy_until = 0;
  endtask

  task automatic check_reset_vals();
    check("rst_wused", rd_if.wused, 0);
    check("rst_nwvf", rd_if.n_wvf_in_buf, 0);
    check("rst_hdr_empty", rd_if.hdr_empty, 1);
    check("rst_hdr_full", rd_if.hdr_full, 0);
    check("rst_overflow", rd_if.overflow, 0);
    check("rst_data", rd_if.wvb_data_out, 0);
  endtask

  // One clock: drive a fresh sample, advance the model, then compare.
  task automatic cycle();
    logic [21:0] popped;
    logic [12:0] s;
    bit pop_ok;
    int pre_wused, pre_hcnt, pre_nwvf, n, k;
    adc_in = 12'($urandom);
    discr_in = 1'($urandom);
    ltc_in = ltc_v;
    hist[cyc] = {discr_in, adc_in};
    pop_ok = 1'b0;
    popped = '0;
    if (!in_reset) begin
      pre_wused = mwused;
      pre_hcnt = mhq.size();
      pre_nwvf = mnwvf;
      if (rd_if.hdr_rdreq && pre_hcnt > 0) void'(mhq.pop_front());
      if (rd_if.wvb_rdreq && pre_wused > 0) begin
        pop_ok = 1'b1;
        popped = mq.pop_front();
        mwused--;
      end
      if (rd_if.wvb_rddone && pre_nwvf > 0) mnwvf--;
      n = int'(pre_conf) + int'(post_conf) + 1;
      if (cyc >= busy_until && trig && armed) begin
        if (4096 - pre_wused >= n && pre_hcnt < 16) begin
          acc_c = cyc; acc_n = n; acc_pre = int'(pre_conf); acc_src = trig_src;
          acc_ltc = ltc_v - 48'(pre_conf);
          acc_start = mwr_total % 4096;
          busy_until = cyc + n + 1;
        end else begin
          movf = 1'b1;
        end
      end
      if (cyc < busy_until && cyc >= acc_c && cyc < acc_c + acc_n) begin
        k = cyc - acc_c;
        s = hist[cyc - acc_pre];
        mq.push_back({(k == acc_n - 1), s[12], 8'h00, s[11:0]});
        mwused++;
        mwr_total++;
      end
      if (cyc < busy_until && cyc == acc_c + acc_n) begin
        mhq.push_back({acc_ltc, 12'(acc_start), 12'((acc_start + acc_n - 1) % 4096), acc_src, 4'h0});
        mnwvf++;
      end
    end
    @(posedge clk);
    #1;
    if (!in_reset) begin
      check("wused", rd_if.wused, 80'(mwused));
      check("n_wvf", rd_if.n_wvf_in_buf, 80'(mnwvf));
      check("hdr_empty", rd_if.hdr_empty, mhq.size() == 0);
      check("hdr_full", rd_if.hdr_full, mhq.size() == 16);
      check("overflow", rd_if.overflow, movf);
      if (pop_ok) check("data", rd_if.wvb_data_out, popped);
      if (mhq.size() > 0) check("hdr_head", rd_if.hdr_data_out, mhq[0]);
    end
    cyc++;
    ltc_v++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic fire(input int pre, input int post);
    pre_conf = 5'(pre);
    post_conf = 8'(post);
    trig_src = 4'($urandom);
    armed = 1'b1;
    trig = 1'b1;
    $display("trig pre=%0d post=%0d ltc=%0d wused=%0d", pre, post, ltc_v, mwused);
    cycle();
    trig = 1'b0;
    idle(pre + post + 3);
  endtask

  task automatic clear_ctrl();
    trig = 1'b0;
    rd_if.wvb_rdreq = 1'b0;
    rd_if.hdr_rdreq = 1'b0;
    rd_if.wvb_rddone = 1'b0;
  endtask

  task automatic do_reset();
    clear_ctrl();
    rst_n = 1'b0;
    in_reset = 1'b1;
    model_clear();
    #1;
    check_reset_vals();
    repeat (2) cycle();
    rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    clear_ctrl();
    #2;
    rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    check_reset_vals();
    repeat (3) cycle();
    rst_n = 1'b1;
    in_reset = 1'b0;

    // Basic capture: trigger when ltc_in == 100.
    idle(37);
    pre_conf = 5'd3; post_conf = 8'd4; armed = 1'b1; trig_src = 4'hA; trig = 1'b1;
    $display("trig pre=3 post=4 ltc=%0d", ltc_v);
    cycle();
    trig = 1'b0;
    idle(10);
    check("wused_basic", rd_if.wused, 8);
    check("hdr_basic", rd_if.hdr_data_out, {48'd97, 12'd0, 12'd7, 4'hA, 4'h0});

    // Reader drains it.
    rd_if.wvb_rdreq = 1'b1;
    idle(8);
    rd_if.wvb_rdreq = 1'b0;
    rd_if.hdr_rdreq = 1'b1;
    cycle();
    rd_if.hdr_rdreq = 1'b0;
    rd_if.wvb_rddone = 1'b1;
    cycle();
    rd_if.wvb_rddone = 1'b0;
    check("wused_drained", rd_if.wused, 0);
    check("nwvf_drained", rd_if.n_wvf_in_buf, 0);

    // Random traffic, including N=1 waveforms and unarmed triggers.
    for (int i = 0; i < 400; i++) begin
      armed = ($urandom_range(0, 9) != 0);
      trig = ($urandom_range(0, 7) == 0);
      trig_src = 4'($urandom);
      pre_conf = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      post_conf = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 20));
      rd_if.wvb_rdreq = ($urandom_range(0, 2) != 0);
      rd_if.hdr_rdreq = ($urandom_range(0, 5) == 0);
      rd_if.wvb_rddone = ($urandom_range(0, 7) == 0);
      cycle();
    end
    trig = 1'b0;
    rd_if.wvb_rdreq = 1'b1; rd_if.hdr_rdreq = 1'b1; rd_if.wvb_rddone = 1'b1;
    idle(300);
    clear_ctrl();

    // Memory nearly full: 4090 words stored, N=8 dropped, then accepted.
    do_reset();
    for (int i = 0; i < 14; i++) fire(31, 255);
    fire(31, 40);
    check("wused_4090", rd_if.wused, 4090);
    fire(0, 7);
    check("ovf_space", rd_if.overflow, 1);
    check("wused_nowrite", rd_if.wused, 4090);
    rd_if.wvb_rdreq = 1'b1;
    idle(10);
    rd_if.wvb_rdreq = 1'b0;
    fire(0, 7);
    check("wused_after", rd_if.wused, 4088);
    check("hdr_full_16", rd_if.hdr_full, 1);

    // Header FIFO full drops the next trigger.
    do_reset();
    for (int i = 0; i < 16; i++) fire(0, 1);
    check("hdr_full", rd_if.hdr_full, 1);
    check("ovf_before", rd_if.overflow, 0);
    fire(0, 1);
    check("ovf_hdrfull", rd_if.overflow, 1);
    check("nwvf_16", rd_if.n_wvf_in_buf, 16);

    // Address wrap: waveform starting at 4092.
    do_reset();
    for (int i = 0; i < 14; i++) fire(31, 255);
    fire(31, 42);
    check("wused_4092", rd_if.wused, 4092);
    rd_if.wvb_rdreq = 1'b1;
    rd_if.hdr_rdreq = 1'b1;
    idle(15);
    rd_if.hdr_rdreq = 1'b0;
    idle(85);
    rd_if.wvb_rdreq = 1'b0;
    fire(0, 7);
    check("hdr_wrap_adr", rd_if.hdr_data_out[31:8], {12'd4092, 12'd3});
    rd_if.wvb_rdreq = 1'b1; rd_if.hdr_rdreq = 1'b1; rd_if.wvb_rddone = 1'b1;
    idle(4100);
    clear_ctrl();
    check("wused_wrap_drained", rd_if.wused, 0);

    // ltc_start wraps modulo 2^48.
    ltc_v = 48'd2;
    fire(5, 2);
    check("hdr_ltc_wrap", rd_if.hdr_data_out[79:32], 48'hFFFF_FFFF_FFFD);

    // Reset in the middle of a recording.
    pre_conf = 5'd5; post_conf = 8'd20; armed = 1'b1; trig = 1'b1;
    cycle();
    trig = 1'b0;
    idle(5);
    do_reset();
    idle(30);
    check("mid_rst_hdr_empty", rd_if.hdr_empty, 1);
    check("mid_rst_nwvf", rd_if.n_wvf_in_buf, 0);
    check("mid_rst_wused", rd_if.wused, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
